// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory handshake and loads the MEM/WB register.
// Latency: MEM/WB captures on the next posedge; memory waits add one cycle per dm_ready=0 cycle.
// Backpressure: oStall holds the upstream pipeline while a request waits for dm_ready.
//
// Ports:
//   clk, res                 clock, async active-low reset
//   ivalid .. iNextInst      EX/MEM register contents
//   dm_*                     data-memory request / response
//   oStall, oPCSrc, oBranchTarget   pipeline control back to IF/ID/EX
//   ovalid .. oMisalign      MEM/WB register outputs
module mem_stage (
    input  logic        clk,
    input  logic        res,
    input  logic        ivalid,
    input  logic [31:0] iMemAdd,
    input  logic [31:0] iMemData,
    input  logic [4:0]  iRegDest,
    input  logic        iRegWrite,
    input  logic        iMemtoReg,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        ibranch,
    input  logic        izero,
    input  logic [31:0] iNextInst,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        oStall,
    output logic        oPCSrc,
    output logic [31:0] oBranchTarget,
    output logic        ovalid,
    output logic        oRegWrite,
    output logic        oMemtoReg,
    output logic [4:0]  oRegDest,
    output logic [31:0] oReadData,
    output logic [31:0] oAluResult,
    output logic        oMisalign
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic [4:0]  r_regdest;
    logic [31:0] r_readdata;
    logic [31:0] r_aluresult;
    logic        r_misalign;

    logic w_memop;
    logic w_aligned;
    logic w_req;
    logic w_stall;
    logic w_done;

    assign w_memop   = ivalid & (iMemRead | iMemWrite);
    assign w_aligned = (iMemAdd[1:0] == 2'b00);
    // Gating with res makes the request drop the instant reset asserts,
    // even if the EX/MEM slot still presents the same memop.
    assign w_req     = res & ((r_state == S_ACCESS) | (w_memop & w_aligned));
    assign w_stall   = w_req & ~dm_ready;
    assign w_done    = w_req & dm_ready;

    // Address/data/direction come straight from EX/MEM, which the stall keeps stable.
    assign dm_req        = w_req;
    assign dm_we         = iMemWrite;
    assign dm_addr       = iMemAdd;
    assign dm_wdata      = iMemData;
    assign oStall        = w_stall;
    assign oPCSrc        = ivalid & ibranch & izero & ~w_stall;
    assign oBranchTarget = iNextInst;

    assign ovalid     = r_valid;
    assign oRegWrite  = r_regwrite;
    assign oMemtoReg  = r_memtoreg;
    assign oRegDest   = r_regdest;
    assign oReadData  = r_readdata;
    assign oAluResult = r_aluresult;
    assign oMisalign  = r_misalign;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_regdest   <= 5'd0;
            r_readdata  <= 32'd0;
            r_aluresult <= 32'd0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                // A zero-wait access (dm_ready already high) never leaves IDLE.
                S_IDLE:   if (w_memop && w_aligned && !dm_ready) r_state <= S_ACCESS;
                S_ACCESS: if (dm_ready) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase

            if (w_stall) begin
                // Bubble into WB while the access is outstanding; other fields hold.
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_misalign <= 1'b0;
            end else begin
                r_valid     <= ivalid;
                // Stores and dropped (misaligned) accesses never write the register file.
                r_regwrite  <= iRegWrite & ~(w_memop & (iMemWrite | ~w_aligned));
                r_memtoreg  <= iMemtoReg;
                r_regdest   <= iRegDest;
                r_aluresult <= iMemAdd;
                if (w_done && !iMemWrite) r_readdata <= dm_rdata;
                r_misalign  <= w_memop & ~w_aligned;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        res;
    logic        ivalid;
    logic [31:0] iMemAdd, iMemData, iNextInst;
    logic [4:0]  iRegDest;
    logic        iRegWrite, iMemtoReg, iMemRead, iMemWrite, ibranch, izero;
    logic        dm_req, dm_we, dm_ready;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        oStall, oPCSrc;
    logic [31:0] oBranchTarget;
    logic        ovalid, oRegWrite, oMemtoReg, oMisalign;
    logic [4:0]  oRegDest;
    logic [31:0] oReadData, oAluResult;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .res(res), .ivalid(ivalid), .iMemAdd(iMemAdd), .iMemData(iMemData),
        .iRegDest(iRegDest), .iRegWrite(iRegWrite), .iMemtoReg(iMemtoReg),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .ibranch(ibranch), .izero(izero),
        .iNextInst(iNextInst), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .oStall(oStall),
        .oPCSrc(oPCSrc), .oBranchTarget(oBranchTarget), .ovalid(ovalid),
        .oRegWrite(oRegWrite), .oMemtoReg(oMemtoReg), .oRegDest(oRegDest),
        .oReadData(oReadData), .oAluResult(oAluResult), .oMisalign(oMisalign)
    );

    typedef struct packed {
        logic        cap;       // 0 = stall bubble: only valid/regwrite/misalign/readdata are defined
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic [4:0]  dest;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic        misalign;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: after every posedge, the MEM/WB register must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ovalid",    {31'd0, ovalid},    {31'd0, e.valid});
            chk("oRegWrite", {31'd0, oRegWrite}, {31'd0, e.regwrite});
            chk("oMisalign", {31'd0, oMisalign}, {31'd0, e.misalign});
            chk("oReadData", oReadData, e.rdata);
            if (e.cap) begin
                chk("oMemtoReg",  {31'd0, oMemtoReg}, {31'd0, e.memtoreg});
                chk("oRegDest",   {27'd0, oRegDest},  {27'd0, e.dest});
                chk("oAluResult", oAluResult, e.alu);
            end
        end
    end

    task automatic set_in(input logic v, rd, wr, rw, m2r, br, z,
                          input logic [31:0] addr, data, nxt, input logic [4:0] dest);
        ivalid = v; iMemRead = rd; iMemWrite = wr; iRegWrite = rw; iMemtoReg = m2r;
        ibranch = br; izero = z; iMemAdd = addr; iMemData = data; iNextInst = nxt;
        iRegDest = dest;
    endtask

    // One EX/MEM instruction, held for as long as the memory makes it wait.
    // lat = number of dm_ready=0 cycles before the memory answers.
    task automatic issue(input logic v, rd, wr, rw, m2r, br, z,
                         input logic [31:0] addr, data, nxt, input logic [4:0] dest,
                         input int lat, input logic [31:0] rdata);
        logic memop, aligned, acc, stall;
        int   ncyc;
        memop   = v & (rd | wr);
        aligned = (addr % 4) == 0;
        acc     = memop & aligned;
        ncyc    = acc ? lat + 1 : 1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            set_in(v, rd, wr, rw, m2r, br, z, addr, data, nxt, dest);
            // Outside a request, a random dm_ready must have no effect.
            dm_ready = acc ? (c == lat) : 1'($urandom_range(0, 1));
            dm_rdata = (acc && c == lat) ? rdata : $urandom();
            stall    = acc && (c < lat);
            #1;
            chk("dm_req",        {31'd0, dm_req}, {31'd0, acc});
            chk("oStall",        {31'd0, oStall}, {31'd0, stall});
            chk("oPCSrc",        {31'd0, oPCSrc}, {31'd0, v & br & z & ~stall});
            chk("oBranchTarget", oBranchTarget, nxt);
            chk("dm_addr",       dm_addr, addr);
            if (acc) begin
                chk("dm_we",    {31'd0, dm_we}, {31'd0, wr});
                chk("dm_wdata", dm_wdata, data);
            end
            if (stall) begin
                m.cap = 1'b0; m.valid = 1'b0; m.regwrite = 1'b0; m.misalign = 1'b0;
            end else begin
                m.cap      = 1'b1;
                m.valid    = v;
                m.regwrite = (memop && (wr || !aligned)) ? 1'b0 : rw;
                m.memtoreg = m2r;
                m.dest     = dest;
                m.alu      = addr;
                if (acc && !wr) m.rdata = rdata;
                m.misalign = memop && !aligned;
            end
            q.push_back(m);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        m = '0;
        res = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
        dm_ready = 1'b0; dm_rdata = 32'd0;
        #12;
        // Reset state
        chk("rst ovalid",     {31'd0, ovalid},    32'd0);
        chk("rst oRegWrite",  {31'd0, oRegWrite}, 32'd0);
        chk("rst oMisalign",  {31'd0, oMisalign}, 32'd0);
        chk("rst oReadData",  oReadData,  32'd0);
        chk("rst oAluResult", oAluResult, 32'd0);
        chk("rst dm_req",     {31'd0, dm_req},    32'd0);
        @(negedge clk); res = 1'b1;

        // Load 0x100, memory answers after 3 wait cycles
        issue(1, 1, 0, 1, 1, 0, 0, 32'h100, 32'h0, 32'h0, 5'd3, 3, 32'hDEADBEEF);
        // Store 0x20 data 0x55, zero-wait
        issue(1, 0, 1, 1, 0, 0, 0, 32'h20, 32'h55, 32'h0, 5'd4, 0, 32'h0);
        // ALU op, result 0x7, dest 5
        issue(1, 0, 0, 1, 0, 0, 0, 32'h7, 32'h0, 32'h0, 5'd5, 0, 32'h0);
        // Misaligned load 0x102, followed by an ALU op so oMisalign must clear
        issue(1, 1, 0, 1, 1, 0, 0, 32'h102, 32'h0, 32'h0, 5'd6, 0, 32'h0);
        issue(1, 0, 0, 1, 0, 0, 0, 32'h8, 32'h0, 32'h0, 5'd7, 0, 32'h0);
        // Branch taken
        issue(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h40, 5'd0, 0, 32'h0);
        // Branch sitting on a stalled load: suppressed until the load completes
        issue(1, 1, 0, 1, 1, 1, 1, 32'h44, 32'h0, 32'h80, 5'd8, 2, 32'h12345678);
        // Read+write together behaves as a write
        issue(1, 1, 1, 1, 0, 0, 0, 32'h48, 32'hA5A5, 32'h0, 5'd9, 1, 32'hFFFF0000);
        // Bubble with a stray dm_ready
        issue(0, 0, 0, 0, 0, 0, 0, 32'h4C, 32'h0, 32'h0, 5'd0, 0, 32'h0);

        // Reset in the middle of an outstanding load
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_in(1, 1, 0, 1, 1, 0, 0, 32'h200, 32'h0, 32'h0, 5'd10);
            dm_ready = 1'b0;
            #1;
            chk("abort dm_req pre", {31'd0, dm_req}, 32'd1);
            m.cap = 1'b0; m.valid = 1'b0; m.regwrite = 1'b0; m.misalign = 1'b0;
            q.push_back(m);
        end
        @(negedge clk); #2;
        res = 1'b0;
        #1;
        chk("abort dm_req",  {31'd0, dm_req}, 32'd0);
        chk("abort ovalid",  {31'd0, ovalid}, 32'd0);
        chk("abort oStall",  {31'd0, oStall}, 32'd0);
        m = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        res = 1'b1;
        // Late dm_ready after release: no request, first capture on next posedge
        @(negedge clk);
        dm_ready = 1'b1;
        #1;
        chk("late dm_req", {31'd0, dm_req}, 32'd0);
        chk("late oStall", {31'd0, oStall}, 32'd0);
        m.cap = 1'b1; m.valid = 1'b0; m.regwrite = 1'b0; m.memtoreg = 1'b0;
        m.dest = 5'd0; m.alu = 32'd0; m.misalign = 1'b0;
        q.push_back(m);
        issue(1, 0, 0, 1, 0, 0, 0, 32'h9, 32'h0, 32'h0, 5'd11, 0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int          kind;
            logic [31:0] a;
            logic        rd, wr, v, rw;
            kind = $urandom_range(0, 5);
            a    = $urandom() & 32'hFFFF_FFFC;
            v = 1'b1; rd = 1'b0; wr = 1'b0;
            rw = 1'($urandom_range(0, 1));
            case (kind)
                1: rd = 1'b1;
                2: wr = 1'b1;
                3: begin rd = 1'($urandom_range(0, 1)); wr = ~rd; a = a | $urandom_range(1, 3); end
                4: begin v = 1'b0; rw = 1'b0; rd = 1'($urandom_range(0, 1)); end
                5: begin rd = 1'b1; wr = 1'b1; end
                default: ;
            endcase
            issue(v, rd, wr, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), a, $urandom(), $urandom(),
                  5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom());
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 res  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-003 ivalid  in  1  EX/MEM slot holds a live instruction.
REQ-004 iMemAdd  in  32  ALU result / data address.
REQ-005 iMemData  in  32  store data.
REQ-006 iRegDest  in  5  destination register.
REQ-007 iRegWrite, iMemtoReg, iMemRead, iMemWrite, ibranch, izero  in  1 each  EX/MEM control bits.
REQ-008 iNextInst  in  32  branch target.
REQ-009 dm_req  out  1  data-memory request.
REQ-010 dm_we  out  1  1 = write, 0 = read.
REQ-011 dm_addr  out  32  word address; always equal to iMemAdd.
REQ-012 dm_wdata  out  32  write data; always equal to iMemData.
REQ-013 dm_ready  in  1  memory done; read data valid in the same cycle.
REQ-014 dm_rdata  in  32  read data.
REQ-015 oStall  out  1  freeze IF/ID/EX and hold EX/MEM inputs stable.
REQ-016 oPCSrc  out  1  take the branch.
REQ-017 oBranchTarget  out  32  redirect PC.
REQ-018 ovalid, oRegWrite, oMemtoReg  out  1 each  MEM/WB register outputs.
REQ-019 oRegDest  out  5  MEM/WB register output.
REQ-020 oReadData, oAluResult  out  32  MEM/WB register outputs.
REQ-021 oMisalign  out  1  registered flag: access dropped because iMemAdd[1:0] != 0.

Function
REQ-022 memop SHALL mean ivalid & (iMemRead | iMemWrite); iMemRead & iMemWrite both set SHALL be treated as a write.
REQ-023 FSM states SHALL be IDLE and ACCESS.
- IDLE -> ACCESS: memop with iMemAdd[1:0]==0.
- ACCESS -> IDLE: dm_ready=1.
REQ-024 dm_req SHALL be 1 in IDLE when an aligned memop is present, and in every ACCESS cycle.
- dm_req, dm_we, dm_addr and dm_wdata SHALL hold constant while dm_ready=0.
REQ-025 oStall SHALL be 1 when dm_req=1 and dm_ready=0; oStall SHALL be 0 otherwise.
REQ-026 If dm_ready is already 1 in the IDLE request cycle, the access completes with zero wait: FSM stays IDLE and MEM/WB captures that cycle.
REQ-027 Non-memop or bubble: MEM/WB SHALL capture the inputs at the next posedge (1-cycle latency).
- ovalid = ivalid.
- oAluResult = iMemAdd.
- oReadData holds its previous value.
REQ-028 Read completion: MEM/WB SHALL capture on the posedge where dm_ready=1, with oReadData = dm_rdata and the remaining fields from the inputs.
REQ-029 Write completion: MEM/WB SHALL capture on the posedge where dm_ready=1, with oRegWrite forced to 0.
REQ-030 While oStall=1, MEM/WB SHALL load a bubble every cycle: ovalid=0, oRegWrite=0.
REQ-031 Misaligned memop:
- no dm_req, no stall;
- MEM/WB captures with ovalid=1, oRegWrite=0;
- oMisalign=1 for exactly one cycle.
REQ-032 oPCSrc SHALL be combinational: ivalid & ibranch & izero & ~oStall.
- oBranchTarget SHALL always equal iNextInst.
REQ-033 dm_ready arriving in IDLE with no request SHALL be ignored.
REQ-034 Data widths SHALL be a fixed 32 bits; there is no byte or halfword access.

Reset
REQ-035 res=0 SHALL asynchronously force the following, regardless of clk:
- FSM to IDLE;
- all MEM/WB outputs and oMisalign to 0.
REQ-036 Reset asserted mid-ACCESS SHALL abandon the access: dm_req falls immediately, and a late dm_ready after release is ignored per REQ-033.
REQ-037 After res returns to 1, the first capture SHALL occur on the next posedge.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Load, addr 0x100, dm_rdata=0xDEADBEEF, dm_ready after 3 cycles -> oStall=1 for 3 cycles, 3 bubbles, then ovalid=1, oReadData=0xDEADBEEF, oRegWrite=1.
- Store, addr 0x20, data 0x55, dm_ready same cycle -> dm_we=1, dm_wdata=0x55, no stall, next cycle ovalid=1, oRegWrite=0.
- ALU op, iMemAdd=0x7, iRegDest=5 -> next cycle oAluResult=0x7, oRegDest=5, dm_req never asserted.
- Load at addr 0x102 -> dm_req=0, oMisalign=1 for one cycle, oRegWrite=0.
- Branch with izero=1, iNextInst=0x40 -> oPCSrc=1, oBranchTarget=0x40; with oStall=1 -> oPCSrc=0.
- res=0 pulse during ACCESS -> dm_req and ovalid drop before the next edge; a later dm_ready is ignored.
